// File: rtl/adjust_controller.sv
// ============================================================================
//  Module      : adjust_controller
//  Description : Time-adjust sequencer for the alarm clock. Detects button
//                rising edges, arbitrates simultaneous presses (C>L>R>U>D),
//                runs the RUN/ADJUST state machine and issues field select
//                plus single-cycle increment/decrement pulses. Leaves ADJUST
//                after TIMEOUT_TICKS ticks without activity.
//  Options     : AUTO_REPEAT_EN - when defined, holding U or D alone emits a
//                pulse after HOLD_TICKS ticks and then every REPEAT_TICKS.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adjust_controller #(
  parameter int HOLD_TICKS    = 500,
  parameter int REPEAT_TICKS  = 100,
  parameter int TIMEOUT_TICKS = 10000,
  parameter int CW            = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_c,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       btn_r,
  output logic       adjust_mode,
  output logic [1:0] sel,
  output logic [3:0] sel_onehot,
  output logic       inc_pulse,
  output logic       dec_pulse
);

  // Tick parameters must fit the counter width and be non-zero.
  if (HOLD_TICKS < 1 || REPEAT_TICKS < 1 || TIMEOUT_TICKS < 1 ||
      HOLD_TICKS > (2**CW - 1) || REPEAT_TICKS > (2**CW - 1) ||
      TIMEOUT_TICKS > (2**CW - 1)) begin : g_param_check
    $error("adjust_controller: tick parameter out of range");
  end

  localparam logic [CW:0] c_timeout = (CW+1)'(TIMEOUT_TICKS);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_ADJUST = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    onehot_q, onehot_d;
  logic          inc_q, inc_d;
  logic          dec_q, dec_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [4:0]    prev_q;           // {c, l, r, u, d}

  logic [4:0]    btn_w;
  logic [4:0]    rise_w;
  logic          acc_c, acc_l, acc_r, acc_u, acc_d, acc_any;
  logic          rep_fire;

  assign btn_w  = {btn_c, btn_l, btn_r, btn_u, btn_d};
  assign rise_w = btn_w & ~prev_q;

  // Fixed-priority arbitration: exactly one rising edge is accepted.
  assign acc_c   = rise_w[4];
  assign acc_l   = rise_w[3] & ~rise_w[4];
  assign acc_r   = rise_w[2] & ~|rise_w[4:3];
  assign acc_u   = rise_w[1] & ~|rise_w[4:2];
  assign acc_d   = rise_w[0] & ~|rise_w[4:1];
  assign acc_any = |rise_w;

`ifdef AUTO_REPEAT_EN
  localparam logic [CW:0] c_hold   = (CW+1)'(HOLD_TICKS);
  localparam logic [CW:0] c_repeat = (CW+1)'(REPEAT_TICKS);

  logic          rep_arm_q, rep_arm_d;     // a U/D hold is being timed
  logic          rep_up_q, rep_up_d;       // 1 = U held, 0 = D held
  logic          rep_phase_q, rep_phase_d; // 0 = waiting HOLD, 1 = repeating
  logic [CW-1:0] hold_q, hold_d;
  logic          rep_only_w;
  logic [CW:0]   rep_term_w;

  // The held button must be the only one high for the hold to keep counting.
  assign rep_only_w = rep_up_q ? (btn_w == 5'b00010) : (btn_w == 5'b00001);
  assign rep_term_w = rep_phase_q ? c_repeat : c_hold;
`endif

  // Next-state, select and pulse decisions.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    tmo_d    = tmo_q;
    rep_fire = 1'b0;
`ifdef AUTO_REPEAT_EN
    rep_arm_d   = rep_arm_q;
    rep_up_d    = rep_up_q;
    rep_phase_d = rep_phase_q;
    hold_d      = hold_q;
    if (rep_arm_q) begin
      if (!rep_only_w) begin
        // Release or another button: drop the hold, even at terminal count.
        rep_arm_d   = 1'b0;
        rep_phase_d = 1'b0;
        hold_d      = '0;
      end else if (tick) begin
        if (({1'b0, hold_q} + (CW+1)'(1)) >= rep_term_w) begin
          rep_fire    = 1'b1;
          rep_phase_d = 1'b1;
          hold_d      = '0;
        end else begin
          hold_d = hold_q + CW'(1);
        end
      end
    end
`endif

    case (state_q)
      ST_RUN: begin
        tmo_d = '0;
        if (acc_c) begin
          state_d = ST_ADJUST;
          sel_d   = 2'd0;
        end
      end
      ST_ADJUST: begin
        if (acc_any) begin
          // An accepted edge beats a coincident timeout.
          tmo_d = '0;
          if (acc_c) begin
            state_d = ST_RUN;
            sel_d   = 2'd0;
          end else if (acc_l) begin
            sel_d = sel_q - 2'd1;
          end else if (acc_r) begin
            sel_d = sel_q + 2'd1;
          end else if (acc_u) begin
            inc_d = 1'b1;
          end else if (acc_d) begin
            dec_d = 1'b1;
          end
`ifdef AUTO_REPEAT_EN
          if (acc_u || acc_d) begin
            rep_arm_d   = 1'b1;
            rep_up_d    = acc_u;
            rep_phase_d = 1'b0;
            hold_d      = '0;
          end
`endif
        end else if (rep_fire) begin
          tmo_d = '0;
`ifdef AUTO_REPEAT_EN
          inc_d = rep_up_q;
          dec_d = ~rep_up_q;
`endif
        end else if (tick) begin
          if (({1'b0, tmo_q} + (CW+1)'(1)) >= c_timeout) begin
            state_d = ST_RUN;
            sel_d   = 2'd0;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        sel_d   = 2'd0;
        tmo_d   = '0;
      end
    endcase

`ifdef AUTO_REPEAT_EN
    if (state_d == ST_RUN) begin
      rep_arm_d   = 1'b0;
      rep_phase_d = 1'b0;
      hold_d      = '0;
    end
`endif

    onehot_d = (state_d == ST_ADJUST) ? (4'b0001 << sel_d) : 4'b0000;
  end

  // State and output registers; reset captures button levels as history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      sel_q    <= 2'd0;
      onehot_q <= 4'b0000;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      tmo_q    <= '0;
      prev_q   <= btn_w;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      onehot_q <= onehot_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      tmo_q    <= tmo_d;
      prev_q   <= btn_w;
    end
  end

`ifdef AUTO_REPEAT_EN
  // Hold/repeat timing registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_arm_q   <= 1'b0;
      rep_up_q    <= 1'b0;
      rep_phase_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      rep_arm_q   <= rep_arm_d;
      rep_up_q    <= rep_up_d;
      rep_phase_q <= rep_phase_d;
      hold_q      <= hold_d;
    end
  end
`endif

  assign adjust_mode = (state_q == ST_ADJUST);
  assign sel         = sel_q;
  assign sel_onehot  = onehot_q;
  assign inc_pulse   = inc_q;
  assign dec_pulse   = dec_q;

endmodule

`default_nettype wire

// File: tb/tb_adjust_controller.sv
// ============================================================================
//  Module      : tb_adjust_controller
//  Description : Directed self-checking bench for adjust_controller with
//                HOLD_TICKS=5, REPEAT_TICKS=2, TIMEOUT_TICKS=8.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adjust_controller;

`ifdef AUTO_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       btn_c = 1'b0, btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
  logic       adjust_mode;
  logic [1:0] sel;
  logic [3:0] sel_onehot;
  logic       inc_pulse, dec_pulse;

  int checks = 0;
  int errors = 0;

  adjust_controller #(
    .HOLD_TICKS    (5),
    .REPEAT_TICKS  (2),
    .TIMEOUT_TICKS (8),
    .CW            (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .btn_c       (btn_c),
    .btn_u       (btn_u),
    .btn_d       (btn_d),
    .btn_l       (btn_l),
    .btn_r       (btn_r),
    .adjust_mode (adjust_mode),
    .sel         (sel),
    .sel_onehot  (sel_onehot),
    .inc_pulse   (inc_pulse),
    .dec_pulse   (dec_pulse)
  );

  always #5 clk = ~clk;

  // One clock edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick = 1'b0;
    {btn_c, btn_u, btn_d, btn_l, btn_r} = 5'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic enter_adjust();
    btn_c = 1'b1;
    step();
    btn_c = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_c = 1'b1;
    step();
    step();
    checks++;
    if (adjust_mode !== 1'b0 || sel !== 2'd0 || sel_onehot !== 4'b0000 ||
        inc_pulse !== 1'b0 || dec_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: mode=%b sel=%0d oh=%b inc=%b dec=%b, want 0 0 0000 0 0",
               adjust_mode, sel, sel_onehot, inc_pulse, dec_pulse);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (adjust_mode !== 1'b0) begin
        errors++;
        $display("FAIL held_c_through_reset cycle %0d: mode=%b want 0", i, adjust_mode);
      end
    end
    btn_c = 1'b0;
    step();
    btn_c = 1'b1;
    step();
    checks++;
    if (adjust_mode !== 1'b1 || sel !== 2'd0 || sel_onehot !== 4'b0001) begin
      errors++;
      $display("FAIL enter_adjust: mode=%b sel=%0d oh=%b want 1 0 0001",
               adjust_mode, sel, sel_onehot);
    end
    btn_c = 1'b0;
    step();
  endtask

  task automatic test_sel_nav();
    btn_l = 1'b1; step();
    checks++;
    if (sel !== 2'd3 || sel_onehot !== 4'b1000) begin
      errors++;
      $display("FAIL sel_left_wrap: sel=%0d oh=%b want 3 1000", sel, sel_onehot);
    end
    btn_l = 1'b0; step();
    btn_r = 1'b1; step();
    checks++;
    if (sel !== 2'd0 || sel_onehot !== 4'b0001) begin
      errors++;
      $display("FAIL sel_right_wrap: sel=%0d oh=%b want 0 0001", sel, sel_onehot);
    end
    btn_r = 1'b0; step();
    btn_r = 1'b1; step();
    checks++;
    if (sel !== 2'd1 || sel_onehot !== 4'b0010) begin
      errors++;
      $display("FAIL sel_right: sel=%0d oh=%b want 1 0010", sel, sel_onehot);
    end
    btn_r = 1'b0; step();
  endtask

  task automatic test_arbitration();
    // sel is 1 on entry
    btn_l = 1'b1; btn_u = 1'b1; step();
    checks++;
    if (sel !== 2'd0 || inc_pulse !== 1'b0) begin
      errors++;
      $display("FAIL arb_l_over_u: sel=%0d inc=%b want 0 0", sel, inc_pulse);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (sel !== 2'd0 || inc_pulse !== 1'b0 || dec_pulse !== 1'b0) begin
        errors++;
        $display("FAIL arb_hold %0d: sel=%0d inc=%b dec=%b want 0 0 0",
                 i, sel, inc_pulse, dec_pulse);
      end
    end
    btn_l = 1'b0; btn_u = 1'b0; step();
    btn_r = 1'b1; step();
    btn_r = 1'b0; step();
    btn_c = 1'b1; btn_r = 1'b1; step();
    checks++;
    if (adjust_mode !== 1'b0 || sel !== 2'd0 || sel_onehot !== 4'b0000) begin
      errors++;
      $display("FAIL arb_c_over_r: mode=%b sel=%0d oh=%b want 0 0 0000",
               adjust_mode, sel, sel_onehot);
    end
    btn_c = 1'b0; btn_r = 1'b0; step();
    btn_u = 1'b1; step();
    checks++;
    if (inc_pulse !== 1'b0 || adjust_mode !== 1'b0) begin
      errors++;
      $display("FAIL run_ignores_u: inc=%b mode=%b want 0 0", inc_pulse, adjust_mode);
    end
    btn_u = 1'b0; step();
    btn_r = 1'b1; step();
    checks++;
    if (sel !== 2'd0 || sel_onehot !== 4'b0000) begin
      errors++;
      $display("FAIL run_ignores_r: sel=%0d oh=%b want 0 0000", sel, sel_onehot);
    end
    btn_r = 1'b0; step();
  endtask

  task automatic test_pulses();
    reset_dut();
    enter_adjust();
    btn_u = 1'b1; step();
    checks++;
    if (inc_pulse !== 1'b1 || dec_pulse !== 1'b0) begin
      errors++;
      $display("FAIL u_pulse: inc=%b dec=%b want 1 0", inc_pulse, dec_pulse);
    end
    step();
    checks++;
    if (inc_pulse !== 1'b0) begin
      errors++;
      $display("FAIL u_pulse_width: inc=%b want 0", inc_pulse);
    end
    btn_u = 1'b0; step();
    btn_d = 1'b1; step();
    checks++;
    if (dec_pulse !== 1'b1 || inc_pulse !== 1'b0) begin
      errors++;
      $display("FAIL d_pulse: dec=%b inc=%b want 1 0", dec_pulse, inc_pulse);
    end
    step();
    checks++;
    if (dec_pulse !== 1'b0) begin
      errors++;
      $display("FAIL d_pulse_width: dec=%b want 0", dec_pulse);
    end
    btn_d = 1'b0; step();
  endtask

  task automatic test_auto_repeat();
    logic exp;
    reset_dut();
    enter_adjust();
    tick = 1'b1;
    btn_u = 1'b1;
    // Held for 13 edges: press pulse, then ticks 5, 7, 9, 11 when enabled.
    for (int i = 0; i < 13; i++) begin
      step();
      exp = (i == 0) || (REP && (i == 5 || i == 7 || i == 9 || i == 11));
      checks++;
      if (inc_pulse !== exp || dec_pulse !== 1'b0) begin
        errors++;
        $display("FAIL repeat_u edge %0d: inc=%b dec=%b want %b 0",
                 i, inc_pulse, dec_pulse, exp);
      end
    end
    // Release exactly at the next terminal count: no pulse.
    btn_u = 1'b0; step();
    checks++;
    if (inc_pulse !== 1'b0) begin
      errors++;
      $display("FAIL release_at_terminal: inc=%b want 0", inc_pulse);
    end
    tick = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    reset_dut();
    enter_adjust();
    btn_r = 1'b1; step(); btn_r = 1'b0; step();
    btn_r = 1'b1; step(); btn_r = 1'b0; step();
    checks++;
    if (sel !== 2'd2) begin
      errors++;
      $display("FAIL timeout_setup_sel: sel=%0d want 2", sel);
    end
    tick = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (i < 8 && adjust_mode !== 1'b1) begin
        errors++;
        $display("FAIL timeout_early tick %0d: mode=%b want 1", i, adjust_mode);
      end else if (i == 8 && (adjust_mode !== 1'b0 || sel !== 2'd0 || sel_onehot !== 4'b0000)) begin
        errors++;
        $display("FAIL timeout_exit: mode=%b sel=%0d oh=%b want 0 0 0000",
                 adjust_mode, sel, sel_onehot);
      end
    end
    tick = 1'b0;
    reset_dut();
    enter_adjust();
    tick = 1'b1;
    for (int i = 0; i < 6; i++) step();
    btn_u = 1'b1; step();
    checks++;
    if (adjust_mode !== 1'b1 || inc_pulse !== 1'b1) begin
      errors++;
      $display("FAIL timeout_restart_press: mode=%b inc=%b want 1 1", adjust_mode, inc_pulse);
    end
    btn_u = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (adjust_mode !== (i < 8)) begin
        errors++;
        $display("FAIL timeout_restart tick %0d: mode=%b want %b", i, adjust_mode, (i < 8));
      end
    end
    tick = 1'b0;
  endtask

  task automatic test_reset_mid_repeat();
    reset_dut();
    enter_adjust();
    tick = 1'b1;
    btn_d = 1'b1; step();
    checks++;
    if (dec_pulse !== 1'b1) begin
      errors++;
      $display("FAIL mid_press_d: dec=%b want 1", dec_pulse);
    end
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (dec_pulse !== (REP && i == 5)) begin
        errors++;
        $display("FAIL mid_hold_d %0d: dec=%b want %b", i, dec_pulse, (REP && i == 5));
      end
    end
    rst = 1'b1; step();
    checks++;
    if (dec_pulse !== 1'b0 || adjust_mode !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_repeat: dec=%b mode=%b want 0 0", dec_pulse, adjust_mode);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (dec_pulse !== 1'b0) begin
        errors++;
        $display("FAIL post_rst_run %0d: dec=%b want 0", i, dec_pulse);
      end
    end
    btn_c = 1'b1; step();
    btn_c = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (dec_pulse !== 1'b0 || adjust_mode !== 1'b1) begin
        errors++;
        $display("FAIL post_rst_adjust %0d: dec=%b mode=%b want 0 1", i, dec_pulse, adjust_mode);
      end
    end
    tick = 1'b0;
    btn_d = 1'b0; step();
    btn_d = 1'b1; step();
    checks++;
    if (dec_pulse !== 1'b1) begin
      errors++;
      $display("FAIL repress_d: dec=%b want 1", dec_pulse);
    end
    btn_d = 1'b0; step();
  endtask

  initial begin
    test_reset();
    test_sel_nav();
    test_arbitration();
    test_pulses();
    test_auto_repeat();
    test_timeout();
    test_reset_mid_repeat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
